// File: rtl/pc_capture_ctrl.sv
// Program-counter capture and run/step/breakpoint controller for a 6502 front panel.
// Debounces the step button, freezes the CPU via RDY and latches opcode-fetch addresses.
module pc_capture_ctrl #(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_sync,
  input  logic        sw_run,
  input  logic        btn_step,
  input  logic        bp_en,
  input  logic [15:0] bp_addr,
  output logic [15:0] pc_disp,
  output logic        cpu_rdy,
  output logic        halted,
  output logic        bp_hit
);

  typedef enum logic [1:0] {RUN, HALT, SKIP, STEP} state_t;

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

  state_t      state_q, state_d;
  logic        btnSync1_q, btnSync2_q;
  logic        level_q, level_d;
  logic        levelPrev_q;
  logic [15:0] dbCnt_q, dbCnt_d;
  logic [15:0] pc_q, pc_d;
  logic        bpHit_q, bpHit_d;

  logic        stepPulse;
  logic        match;
  logic        haltNow;

  // The level only flips once the synchronised input has disagreed for DB_CYCLES edges in a row.
  always_comb begin
    level_d = level_q;
    dbCnt_d = '0;
    if (btnSync2_q != level_q) begin
      if (dbCnt_q == DB_LAST) begin
        level_d = btnSync2_q;
      end else begin
        dbCnt_d = dbCnt_q + 16'd1;
      end
    end
  end

  assign stepPulse = level_q & ~levelPrev_q;
  assign match     = bp_en && cpu_sync && (cpu_addr == bp_addr);
  assign haltNow   = cpu_sync && (((state_q == RUN) && (!sw_run || match)) || (state_q == STEP));
  assign cpu_rdy   = (state_q != HALT) && !haltNow;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bpHit_d = bpHit_q;
    if (((state_q == RUN) || (state_q == STEP)) && cpu_sync) begin
      pc_d = cpu_addr;
    end
    unique case (state_q)
      RUN: begin
        if (haltNow) begin
          state_d = HALT;
          if (match) begin
            bpHit_d = 1'b1;
          end
        end
      end
      HALT: begin
        if (stepPulse) begin
          state_d = SKIP;
          bpHit_d = 1'b0;
        end
      end
      // Wait for the held fetch to retire so the same address is not captured or matched again.
      SKIP: begin
        if (!cpu_sync) begin
          state_d = sw_run ? RUN : STEP;
        end
      end
      STEP: begin
        if (cpu_sync) begin
          state_d = HALT;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      btnSync1_q  <= 1'b0;
      btnSync2_q  <= 1'b0;
      level_q     <= 1'b0;
      levelPrev_q <= 1'b0;
      dbCnt_q     <= '0;
      pc_q        <= '0;
      bpHit_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      btnSync1_q  <= btn_step;
      btnSync2_q  <= btnSync1_q;
      level_q     <= level_d;
      levelPrev_q <= level_q;
      dbCnt_q     <= dbCnt_d;
      pc_q        <= pc_d;
      bpHit_q     <= bpHit_d;
    end
  end

  assign pc_disp = pc_q;
  assign halted  = (state_q == HALT);
  assign bp_hit  = bpHit_q;

endmodule

// File: doc/pc_capture_ctrl.md
PC_CAPTURE_CTRL -- requirements
Module: pc_capture_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 50000, giving the number of stable clk cycles required to accept a new debounced step-button level (range 2..65535).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cpu_addr  input  16  6502 address bus.
REQ-005 cpu_sync  input  1  6502 SYNC; high during opcode-fetch cycles.
REQ-006 sw_run  input  1  mode switch (1 = free run, 0 = single step); used unsynchronised, treated as quasi-static.
REQ-007 btn_step  input  1  raw, asynchronous, bouncing step push-button.
REQ-008 bp_en  input  1  breakpoint enable.
REQ-009 bp_addr  input  16  breakpoint address.
REQ-010 pc_disp  output  16  last captured opcode-fetch address; feeds the 16-bit PC input of the seven-segment hex display driver.
REQ-011 cpu_rdy  output  1  6502 RDY; 0 holds the CPU.
REQ-012 halted  output  1  high while the FSM is in HALT.
REQ-013 bp_hit  output  1  sticky breakpoint-hit flag.

Function
REQ-014 btn_step SHALL pass through a 2-flop synchroniser, then a debouncer: the debounced level changes only after the synchronised input differs from it for DB_CYCLES consecutive cycles; any disagreement-free cycle resets the count.
REQ-015 step_pulse SHALL be a single-cycle pulse on each 0->1 transition of the debounced level; holding the button gives exactly one pulse.
REQ-016 The FSM SHALL have states RUN, HALT, SKIP, STEP.
REQ-017 match = bp_en && cpu_sync && (cpu_addr == bp_addr), a full 16-bit equality.
REQ-018 halt_now = cpu_sync && ((state==RUN && (!sw_run || match)) || state==STEP).
REQ-019 cpu_rdy SHALL be combinational: 1 when state != HALT and halt_now == 0, otherwise 0. The CPU is therefore frozen in the same cycle that presents the opcode fetch.
REQ-020 In RUN or STEP, on every cycle with cpu_sync=1, pc_disp SHALL load cpu_addr on the next edge.
REQ-021 RUN -> HALT when halt_now=1; bp_hit SHALL set on the same edge if match=1.
REQ-022 HALT -> SKIP on step_pulse; bp_hit SHALL clear on the same edge.
REQ-023 In HALT, pc_disp SHALL hold its value and cpu_sync SHALL be ignored.
REQ-024 SKIP exists to release the held fetch without recapturing it.
  - cpu_rdy=1 in SKIP.
  - No capture and no halt in SKIP.
  - SKIP -> RUN when cpu_sync=0 and sw_run=1.
  - SKIP -> STEP when cpu_sync=0 and sw_run=0.
  - Otherwise SKIP holds.
REQ-025 In STEP, the next cpu_sync=1 cycle SHALL capture pc_disp, drive cpu_rdy=0, and go to HALT, so exactly one instruction executes per step.
REQ-026 A step_pulse SHALL be ignored in every state except HALT.
REQ-027 With sw_run dropping to 0 while in RUN, the block SHALL halt at the next opcode fetch.
REQ-028 If match and !sw_run coincide, the block SHALL still set bp_hit.
REQ-029 halted SHALL be registered state decode: halted = (state==HALT).

Reset
REQ-030 On rst=1, the block SHALL asynchronously enter RUN with pc_disp=16'h0000, bp_hit=0, halted=0, synchroniser flops=0, debounced level=0 and debounce counter=0.
REQ-031 Asserting rst mid-step or mid-debounce SHALL abandon the operation; after release, no stale step_pulse SHALL occur.
REQ-032 cpu_rdy after reset SHALL follow REQ-019 from state RUN.

Verification
REQ-033 Free-run capture: sw_run=1, bp_en=0, sync pulses at 16'h0200/0203/0205 -> pc_disp=16'h0205, cpu_rdy=1 throughout, halted=0.
REQ-034 Breakpoint: bp_en=1, bp_addr=16'hC010, sync at 16'hC010 -> cpu_rdy=0 in that cycle; next edge halted=1, bp_hit=1, pc_disp=16'hC010.
REQ-035 Single step: sw_run=0, halted at 16'h0300; one clean press, then sync low and sync at 16'h0302 -> SKIP, STEP, HALT; pc_disp=16'h0302, bp_hit=0.
REQ-036 Debounce: DB_CYCLES=8; button glitches of 1..7 cycles -> no step_pulse; level held 8+ cycles -> exactly one pulse; held 1000 cycles -> still one pulse.
REQ-037 Resume: halted with bp_hit=1, sw_run=1, one press, held sync then sync low -> RUN without re-hitting the same breakpoint; later sync at 16'hC010 re-halts.
REQ-038 Async reset: assert rst between edges while in STEP -> outputs immediately at reset values (pc_disp=0, halted=0, bp_hit=0) with no clock edge.
